// File: rtl/balldet_pkg.sv
// balldet_pkg - shared definitions for the ball-detector line-buffer path.
//
// Contents:
//   SRAM_AW / SRAM_DW   geometry of the line-buffer SRAM read port
//   REQ_SPI / REQ_SCAN  requester ids carried in the read tag
//   gnt_sel_t           winner of the read-port arbitration in one cycle
package balldet_pkg;

    localparam int SRAM_AW = 12;
    localparam int SRAM_DW = 16;

    localparam logic REQ_SPI  = 1'b0;
    localparam logic REQ_SCAN = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_SPI  = 2'd1,
        GNT_SCAN = 2'd2
    } gnt_sel_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe - shift register of read tags {valid, id}, DEPTH stages deep.
//
// A tag written on one edge appears on out_valid/out_id DEPTH cycles later,
// lining up with the SRAM data for the read it describes.
//
// Ports:
//   clk        system clock
//   res        asynchronous active-low clear
//   in_valid   a read was accepted this cycle
//   in_id      requester id of that read
//   out_valid  tag at the end of the pipe is valid
//   out_id     requester id of that tag
module rd_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic res,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id
);

    logic [DEPTH-1:0] valid_sr;
    logic [DEPTH-1:0] id_sr;

    // NOTE: the valid bits must be reset so that reads in flight at reset
    // can never surface as phantom responses; the id bits are reset only to
    // keep the pipe fully deterministic.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            valid_sr <= '0;
            id_sr    <= '0;
        end else begin
            valid_sr <= {valid_sr[DEPTH-2:0], in_valid};
            id_sr    <= {id_sr[DEPTH-2:0], in_id};
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_id    = id_sr[DEPTH-1];

endmodule

// File: rtl/sram_rd_arbiter.sv
// sram_rd_arbiter - shares the line-buffer SRAM read port between the SPI
// readout engine (fixed priority) and the ball-search scanner (protected
// from starvation by an aging counter).
//
// At most one read is accepted per cycle. The accepted address is registered
// onto rdaddr, and a {valid, id} tag travels alongside the SRAM latency so
// that rddata is steered to the requester that issued the read.
//
// Ports:
//   clk, res                    clock, asynchronous active-low reset
//   freeze                      blocks all grants (line rewrite in progress)
//   spi_req/spi_addr/spi_gnt    SPI request handshake
//   spi_rvalid/spi_rdata        SPI read response
//   scan_req/scan_addr/scan_gnt scanner request handshake
//   scan_rvalid/scan_rdata      scanner read response
//   rdaddr/rddata               SRAM read address and read data
module sram_rd_arbiter
    import balldet_pkg::*;
#(
    parameter int AW       = SRAM_AW,
    parameter int DW       = SRAM_DW,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          freeze,
    input  logic          spi_req,
    input  logic [AW-1:0] spi_addr,
    output logic          spi_gnt,
    output logic          spi_rvalid,
    output logic [DW-1:0] spi_rdata,
    input  logic          scan_req,
    input  logic [AW-1:0] scan_addr,
    output logic          scan_gnt,
    output logic          scan_rvalid,
    output logic [DW-1:0] scan_rdata,
    output logic [AW-1:0] rdaddr,
    input  logic [DW-1:0] rddata
);

    // One stage per cycle between acceptance and rddata being valid.
    localparam int TAG_DEPTH = RD_LAT + 1;

    gnt_sel_t   sel;
    logic [7:0] wait_cnt;
    logic       aged;
    logic       tag_valid;
    logic       tag_id;

    assign aged = (wait_cnt >= 8'(MAX_WAIT));

    // Grants are held off during reset so every output reads 0 while res is low.
    // NOTE: sel gets its default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        sel = GNT_NONE;
        if (res && !freeze) begin
            if (aged && scan_req) begin
                sel = GNT_SCAN;
            end else if (spi_req) begin
                sel = GNT_SPI;
            end else if (scan_req) begin
                sel = GNT_SCAN;
            end
        end
    end

    assign spi_gnt  = (sel == GNT_SPI);
    assign scan_gnt = (sel == GNT_SCAN);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rdaddr   <= '0;
            wait_cnt <= '0;
        end else begin
            case (sel)
                GNT_SPI:  rdaddr <= spi_addr;
                GNT_SCAN: rdaddr <= scan_addr;
                default:  rdaddr <= rdaddr;
            endcase

            // A dropped scan request leaves no age behind; freeze only pauses it.
            if (scan_gnt || !scan_req) begin
                wait_cnt <= '0;
            end else if (!freeze && (wait_cnt != 8'hFF)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    rd_tag_pipe #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_pipe (
        .clk       (clk),
        .res       (res),
        .in_valid  (spi_gnt || scan_gnt),
        .in_id     (scan_gnt ? REQ_SCAN : REQ_SPI),
        .out_valid (tag_valid),
        .out_id    (tag_id)
    );

    assign spi_rvalid  = tag_valid && (tag_id == REQ_SPI);
    assign scan_rvalid = tag_valid && (tag_id == REQ_SCAN);
    assign spi_rdata   = spi_rvalid  ? rddata : '0;
    assign scan_rdata  = scan_rvalid ? rddata : '0;

endmodule
